// File: rtl/mdu_iter_if.sv
// Request/result bundle between the MIPS231 control/datapath and the mdu_iter unit.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Requester side: issues operations, observes status and HI/LO
    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one result bit per cycle on
// magnitudes, with the sign fix-up applied in a final FIX cycle.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle
// combinational multiplier instead of the iterative path.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // product upper half / partial remainder
    logic [WIDTH-1:0] sh_q, sh_d;        // multiplier bits out / dividend out, quotient in
    logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] src_a_q, src_a_d;  // raw dividend, returned in HI on divide by zero
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             op_signed_c;
    logic             a_neg_c, b_neg_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_sh_c;
    logic [WIDTH-1:0] div_diff_c;
    logic             div_ge_c;
    logic [PW-1:0]    prod_c, prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

    // Operand conditioning at accept: signed ops iterate on magnitudes
    always_comb begin
        op_signed_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_neg_c     = op_signed_c && bus.a[WIDTH-1];
        b_neg_c     = op_signed_c && bus.b[WIDTH-1];
        a_mag_c     = a_neg_c ? WIDTH'(-bus.a) : bus.a;
        b_mag_c     = b_neg_c ? WIDTH'(-bus.b) : bus.b;
    end

    // One iteration step: shift-add for multiply, trial subtract for divide
    always_comb begin
        mul_sum_c  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
        div_sh_c   = {acc_q, sh_q[WIDTH-1]};
        div_ge_c   = (div_sh_c >= {1'b0, opnd_q});
        div_diff_c = div_sh_c[WIDTH-1:0] - opnd_q;
    end

    // Sign restoration of the magnitude results
    always_comb begin
        prod_c     = {acc_q, sh_q};
        prod_fix_c = (neg_a_q ^ neg_b_q) ? PW'(-prod_c) : prod_c;
        quo_fix_c  = (neg_a_q ^ neg_b_q) ? WIDTH'(-sh_q) : sh_q;
        rem_fix_c  = neg_a_q ? WIDTH'(-acc_q) : acc_q;
    end

`ifdef MDU_FAST_MUL_EN
    logic [PW-1:0] fast_prod_c;

    // Single-cycle full-width product; low PW bits of sign-extended operands
    always_comb begin
        if (bus.op == OP_MULT) begin
            fast_prod_c = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        end else begin
            fast_prod_c = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        end
    end
`endif

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opnd_d   = opnd_q;
        src_a_d  = src_a_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                            hi_d   = fast_prod_c[PW-1:WIDTH];
                            lo_d   = fast_prod_c[WIDTH-1:0];
                            done_d = 1'b1;
`else
                            state_d  = S_RUN;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            acc_d    = '0;
                            sh_d     = b_mag_c;
                            opnd_d   = a_mag_c;
                            is_div_d = 1'b0;
                            neg_a_d  = a_neg_c;
                            neg_b_d  = b_neg_c;
                            dz_d     = 1'b0;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_RUN;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            acc_d    = '0;
                            sh_d     = a_mag_c;
                            opnd_d   = b_mag_c;
                            src_a_d  = bus.a;
                            is_div_d = 1'b1;
                            neg_a_d  = a_neg_c;
                            neg_b_d  = b_neg_c;
                            dz_d     = (bus.b == '0);
                        end
                        OP_MTHI: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end

            S_RUN: begin
                if (is_div_q) begin
                    if (div_ge_c) begin
                        acc_d = div_diff_c;
                        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh_c[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum_c[WIDTH:1];
                    sh_d  = {mul_sum_c[0], sh_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (is_div_q) begin
                    if (dz_q) begin
                        hi_d = src_a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix_c;
                        lo_d = quo_fix_c;
                    end
                end else begin
                    hi_d = prod_fix_c[PW-1:WIDTH];
                    lo_d = prod_fix_c[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opnd_q   <= '0;
            src_a_q  <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opnd_q   <= opnd_d;
            src_a_q  <= src_a_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter (WIDTH=32): arithmetic reference model plus
// directed vectors with hand-computed results and latencies.
module tb_mdu_iter;

    localparam int unsigned W = 32;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int MD_LAT   = 34;
    localparam int MD_BUSY  = 33;
    localparam int MUL_LAT  = FAST ? 1 : 34;
    localparam int MUL_BUSY = FAST ? 0 : 33;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}
    function automatic logic [63:0] mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            OP_MULT:  r = 64'(sa * sb);
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0)                                 r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, a};
                else                                            r = {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Cycle-level behavioural model of the observable outputs
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_res  <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    {m_hi, m_lo} <= m_res;
                    m_busy       <= 1'b0;
                    m_done       <= 1'b1;
                end
                m_left <= m_left - 1;
            end else if (bus.start) begin
                if (!bus.op[2]) begin
                    if (FAST && !bus.op[1]) begin
                        {m_hi, m_lo} <= mdu_ref(bus.op, bus.a, bus.b);
                        m_done       <= 1'b1;
                    end else begin
                        m_res  <= mdu_ref(bus.op, bus.a, bus.b);
                        m_busy <= 1'b1;
                        m_left <= W + 1;
                    end
                end else if (bus.op == OP_MTHI) begin
                    m_hi   <= bus.a;
                    m_done <= 1'b1;
                end else if (bus.op == OP_MTLO) begin
                    m_lo   <= bus.a;
                    m_done <= 1'b1;
                end else begin
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
            chk("cyc_done", 64'(bus.done), 64'(m_done));
            chk("cyc_hi",   64'(bus.hi),   64'(m_hi));
            chk("cyc_lo",   64'(bus.lo),   64'(m_lo));
        end
    end

    // Issue one op at a negedge; returns start-to-done cycles and busy cycles
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (bus.busy) bcnt++;
        end while (!bus.done && lat < 100);
        chk("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic run_chk(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input int exp_lat, input int exp_busy);
        int lat, bcnt;
        run(op, a, b, lat, bcnt);
        chk({name, "_hi"},   64'(bus.hi), 64'(exp_hi));
        chk({name, "_lo"},   64'(bus.lo), 64'(exp_lo));
        chk({name, "_lat"},  64'(lat),    64'(exp_lat));
        chk({name, "_busy"}, 64'(bcnt),   64'(exp_busy));
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;

        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_chk("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, MUL_BUSY);
        run_chk("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7,
                32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, MUL_BUSY);
        run_chk("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000,
                32'h4000_0000, 32'h0000_0000, MUL_LAT, MUL_BUSY);
        run_chk("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, MD_LAT, MD_BUSY);
        run_chk("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
                32'h0000_0001, 32'hFFFF_FFFD, MD_LAT, MD_BUSY);
        run_chk("divu_7_2", OP_DIVU, 32'd7, 32'd2,
                32'd1, 32'd3, MD_LAT, MD_BUSY);
        run_chk("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0,
                32'h0000_1234, 32'hFFFF_FFFF, MD_LAT, MD_BUSY);
        run_chk("div_by0", OP_DIV, 32'hFFFF_FF00, 32'd0,
                32'hFFFF_FF00, 32'hFFFF_FFFF, MD_LAT, MD_BUSY);
        run_chk("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0000_0000, 32'h8000_0000, MD_LAT, MD_BUSY);
        run_chk("mthi", OP_MTHI, 32'hCAFE_F00D, 32'd0,
                32'hCAFE_F00D, 32'h8000_0000, 1, 0);
        run_chk("mtlo", OP_MTLO, 32'h1234_5678, 32'd0,
                32'hCAFE_F00D, 32'h1234_5678, 1, 0);
        run_chk("nop", OP_NOP, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                32'hCAFE_F00D, 32'h1234_5678, 1, 0);

        // A start presented while busy must be neither accepted nor queued
        bus.start = 1'b1;
`ifdef MDU_FAST_MUL_EN
        bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
`else
        bus.op = OP_MULT; bus.a = 32'd6;   bus.b = 32'd7;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
`ifdef MDU_FAST_MUL_EN
        bus.op = OP_MULT; bus.a = 32'd9;   bus.b = 32'd9;
`else
        bus.op = OP_DIV;  bus.a = 32'd100; bus.b = 32'd3;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_done", 64'(bus.done), 64'd1);
`ifdef MDU_FAST_MUL_EN
        chk("ign_hi", 64'(bus.hi), 64'd2);
        chk("ign_lo", 64'(bus.lo), 64'd14);
`else
        chk("ign_hi", 64'(bus.hi), 64'd0);
        chk("ign_lo", 64'(bus.lo), 64'd42);
`endif
        @(negedge clk);
        chk("ign_no_2nd_done", 64'(bus.done), 64'd0);

        // Asynchronous reset in the middle of a divide
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'h0000_FFFF;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_hi",   64'(bus.hi),   64'd0);
        chk("arst_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_chk("multu_3x5", OP_MULTU, 32'd3, 32'd5,
                32'd0, 32'd15, MUL_LAT, MUL_BUSY);
        // Back-to-back issue in the done cycle
        run_chk("b2b_divu", OP_DIVU, 32'd100, 32'd7,
                32'd2, 32'd14, MD_LAT, MD_BUSY);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
